// File: rtl/if_id_stage_buf_if.sv
// if_id_stage_buf_if: valid/ready beat bus carrying PC, instruction and sideband.
interface if_id_stage_buf_if #(
    parameter int PC_W    = 32,
    parameter int INSTR_W = 32,
    parameter int SIDE_W  = 4
);
    logic               valid;
    logic               ready;
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic [SIDE_W-1:0]  side;
    modport master (output valid, pc, instr, side, input ready);
    modport slave (input valid, pc, instr, side, output ready);
endinterface

// File: rtl/if_id_stage_buf.sv
// if_id_stage_buf: elastic IF/ID stage with valid/ready on both sides and flush.
// Define IF_ID_SKID_EN for the two-entry skid build with a registered in_ready.
module if_id_stage_buf #(
    parameter int                 PC_W      = 32,
    parameter int                 INSTR_W   = 32,
    parameter int                 SIDE_W    = 4,
    parameter logic [PC_W-1:0]    RESET_PC  = 32'h3000,
    parameter logic [INSTR_W-1:0] NOP_INSTR = '0
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              flush_i,
    if_id_stage_buf_if.slave  fetch_i,
    if_id_stage_buf_if.master decode_o,
    output logic [1:0]        occupancy_o
);
`ifdef IF_ID_SKID_EN
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;
`else
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_e;
`endif
    state_e             state_q;
    logic [PC_W-1:0]    m_pc_q;
    logic [INSTR_W-1:0] m_instr_q;
    logic [SIDE_W-1:0]  m_side_q;
    logic               accept;
    logic               drain;
`ifdef IF_ID_SKID_EN
    logic               in_ready_q;
    logic [PC_W-1:0]    s_pc_q;
    logic [INSTR_W-1:0] s_instr_q;
    logic [SIDE_W-1:0]  s_side_q;
    assign fetch_i.ready = in_ready_q;
`else
    assign fetch_i.ready = state_q == EMPTY || decode_o.ready;
`endif
    assign accept         = fetch_i.valid && fetch_i.ready;
    assign drain          = decode_o.valid && decode_o.ready;
    assign decode_o.valid = state_q != EMPTY;
    assign decode_o.pc    = m_pc_q;
    assign decode_o.instr = m_instr_q;
    assign decode_o.side  = m_side_q;
    assign occupancy_o    = state_q;
    // M is loaded directly when it is free or being drained; otherwise the beat parks in S.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q   <= EMPTY;
            m_pc_q    <= RESET_PC;
            m_instr_q <= NOP_INSTR;
            m_side_q  <= '0;
`ifdef IF_ID_SKID_EN
            in_ready_q <= 1'b1;
            s_pc_q     <= '0;
            s_instr_q  <= '0;
            s_side_q   <= '0;
`endif
        end else if (flush_i) begin
            state_q   <= EMPTY;
            m_instr_q <= NOP_INSTR;
            m_side_q  <= '0;
`ifdef IF_ID_SKID_EN
            in_ready_q <= 1'b1;
`endif
        end else if (accept && (state_q == EMPTY || drain)) begin
            state_q   <= ONE;
            m_pc_q    <= fetch_i.pc;
            m_instr_q <= fetch_i.instr;
            m_side_q  <= fetch_i.side;
`ifdef IF_ID_SKID_EN
        end else if (accept) begin
            state_q    <= TWO;
            in_ready_q <= 1'b0;
            s_pc_q     <= fetch_i.pc;
            s_instr_q  <= fetch_i.instr;
            s_side_q   <= fetch_i.side;
        end else if (drain && state_q == TWO) begin
            state_q    <= ONE;
            in_ready_q <= 1'b1;
            m_pc_q     <= s_pc_q;
            m_instr_q  <= s_instr_q;
            m_side_q   <= s_side_q;
`endif
        end else if (drain) begin
            state_q <= EMPTY;
        end
    end
endmodule

// File: tb/tb_if_id_stage_buf.sv
// tb_if_id_stage_buf: directed plus random stimulus against a FIFO-queue model of the stage.
module tb_if_id_stage_buf;
`ifdef IF_ID_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [3:0]  side;
    } beat_t;

    logic       clk;
    logic       rstn;
    logic       flush;
    logic [1:0] occ;
    int         errors;
    int         checks;
    beat_t      q[$];
    beat_t      disp;

    if_id_stage_buf_if #(.PC_W(32), .INSTR_W(32), .SIDE_W(4)) fi ();
    if_id_stage_buf_if #(.PC_W(32), .INSTR_W(32), .SIDE_W(4)) di ();

    if_id_stage_buf dut (
        .clk        (clk),
        .rstn       (rstn),
        .flush_i    (flush),
        .fetch_i    (fi),
        .decode_o   (di),
        .occupancy_o(occ)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not finish, required finish before 1ms");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check DUT against the queue model, then advance the model.
    task automatic step(input logic rn, input logic fl, input logic iv, input logic ordy,
                        input logic [31:0] pc);
        beat_t b;
        logic  exp_rdy;
        logic  acc;
        logic  drn;
        b = '{pc: pc, instr: $urandom, side: 4'($urandom)};
        @(negedge clk);
        rstn = rn;
        flush = fl;
        fi.valid = iv;
        fi.pc = b.pc;
        fi.instr = b.instr;
        fi.side = b.side;
        di.ready = ordy;
        #1;
        exp_rdy = SKID ? (q.size() < 2) : (q.size() == 0 || ordy);
        chk("in_ready", 64'(fi.ready), 64'(exp_rdy));
        chk("out_valid", 64'(di.valid), 64'(q.size() != 0));
        chk("occupancy", 64'(occ), 64'(q.size()));
        chk("out_pc", 64'(di.pc), 64'(disp.pc));
        chk("out_instr", 64'(di.instr), 64'(disp.instr));
        chk("out_side", 64'(di.side), 64'(disp.side));
        @(posedge clk);
        acc = iv && exp_rdy;
        drn = q.size() != 0 && ordy;
        if (!rn) begin
            q.delete();
            disp = '{pc: 32'h3000, instr: 32'h0, side: 4'h0};
        end else if (fl) begin
            q.delete();
            disp.instr = 32'h0;
            disp.side = 4'h0;
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) q.push_back(b);
            if (q.size() != 0) disp = q[0];
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rstn = 1'b0;
        flush = 1'b0;
        fi.valid = 1'b1;
        fi.pc = 32'h1234;
        fi.instr = 32'hdeadbeef;
        fi.side = 4'hf;
        di.ready = 1'b0;
        repeat (2) @(posedge clk);
        q.delete();
        disp = '{pc: 32'h3000, instr: 32'h0, side: 4'h0};
        @(negedge clk);
        #1;
        chk("reset out_valid", 64'(di.valid), 64'(0));
        chk("reset out_pc", 64'(di.pc), 64'h3000);
        chk("reset out_instr", 64'(di.instr), 64'(0));
        chk("reset in_ready", 64'(fi.ready), 64'(1));
        chk("reset occupancy", 64'(occ), 64'(0));
        // streaming
        step(1, 0, 1, 1, 32'h3000);
        step(1, 0, 1, 1, 32'h3004);
        step(1, 0, 1, 1, 32'h3008);
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        // backpressure then drain
        step(1, 0, 1, 0, 32'h3000);
        step(1, 0, 1, 0, 32'h3004);
        step(1, 0, 0, 0, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 0, 32'h0);
        // flush while full and C offered
        step(1, 0, 1, 0, 32'h3000);
        step(1, 0, 1, 0, 32'h3004);
        step(1, 1, 1, 0, 32'h300c);
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        // reset with flush while full, then a normal beat
        step(1, 0, 1, 0, 32'h3000);
        step(1, 0, 1, 0, 32'h3004);
        step(0, 1, 1, 0, 32'h3008);
        step(1, 0, 1, 1, 32'h3010);
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        // held beat, then replacement with out_ready raised
        step(1, 0, 1, 0, 32'h3020);
        step(1, 0, 1, 0, 32'h3024);
        step(1, 0, 1, 1, 32'h3028);
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        step(1, 0, 0, 1, 32'h0);
        // random traffic with occasional flush and reset
        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 59) != 0, $urandom_range(0, 19) == 0, 1'($urandom),
                 $urandom_range(0, 9) < 6, $urandom);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
